// File: rtl/sign_mag_pkg.sv
// Shared types and width helpers for the two's-complement / sign-magnitude converter.
// Only the width-independent part of the stage-1 payload is kept here; the top adds the value field.
package sign_mag_pkg;

    localparam int unsigned SM_MAX_W = 64;

    typedef enum logic {
        MODE_TC2SM = 1'b0,
        MODE_SM2TC = 1'b1
    } sm_mode_e;

    typedef struct packed {
        sm_mode_e mode;
        logic     sign;
        logic     is_min;
        logic     is_zero;
        logic     ovf_pre;
    } sm_s1_flags_t;

    function automatic logic [SM_MAX_W-1:0] max_pos(input int unsigned w);
        return (SM_MAX_W'(1) << (w - 1)) - SM_MAX_W'(1);
    endfunction

    function automatic logic [SM_MAX_W-1:0] min_neg(input int unsigned w);
        return SM_MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/sign_magnitude_pipe_stage.sv
// Elastic payload register: one word of storage, advances when empty or when downstream takes it.
module sm_pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/sign_magnitude_pipe.sv
// Two-stage converter between two's complement and sign-magnitude for the Booth multiplier datapath.
// Stage 1 classifies and complements, stage 2 adds one, saturates and drives the outputs.
module sign_magnitude_pipe
    import sign_mag_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [WORD_LENGTH-1:0] in_data,
    input  logic                   in_sign,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] out_data,
    output logic                   out_sign,
    output logic                   out_overflow,
    input  logic                   clear_count,
    output logic [COUNT_WIDTH-1:0] done_count
);

    localparam logic [WORD_LENGTH-1:0] MAX_POS = WORD_LENGTH'(max_pos(WORD_LENGTH));
    localparam logic [WORD_LENGTH-1:0] MIN_NEG = WORD_LENGTH'(min_neg(WORD_LENGTH));

    typedef struct packed {
        sm_s1_flags_t               flags;
        logic [WORD_LENGTH-1:0]     value;
    } s1_payload_t;

    localparam int unsigned S1_W = $bits(s1_payload_t);
    localparam int unsigned S2_W = WORD_LENGTH + 2;

    s1_payload_t       s1_d;
    s1_payload_t       s1_q;
    logic [S1_W-1:0]   s1_d_bits;
    logic [S1_W-1:0]   s1_q_bits;
    logic              s1_valid;
    logic              s2_ready;

    logic [S2_W-1:0]   s2_d;
    logic [S2_W-1:0]   s2_q;

    sm_mode_e               cur_mode;
    logic                   neg;
    logic                   in_is_min;
    logic                   in_is_zero;

    logic [WORD_LENGTH-1:0] res_data;
    logic                   res_sign;
    logic                   res_ovf;

    logic                   fire;

    // Stage 1: pick the sign, one's-complement negatives, and pre-decide overflow
    always_comb begin
        cur_mode   = sm_mode_e'(in_mode);
        in_is_min  = (in_data == MIN_NEG);
        in_is_zero = (in_data == '0);
        neg        = (cur_mode == MODE_SM2TC) ? in_sign : in_data[WORD_LENGTH-1];

        s1_d               = '0;
        s1_d.flags.mode    = cur_mode;
        s1_d.flags.sign    = neg;
        s1_d.flags.is_min  = in_is_min;
        s1_d.flags.is_zero = in_is_zero;
        s1_d.flags.ovf_pre = (cur_mode == MODE_SM2TC) && in_data[WORD_LENGTH-1]
                             && !(in_sign && in_is_min);
        s1_d.value         = neg ? ~in_data : in_data;
    end

    assign s1_d_bits = s1_d;
    assign s1_q      = s1_q_bits;

    sm_pipe_stage #(
        .WIDTH (S1_W)
    ) u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d_bits),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_q_bits)
    );

    // Stage 2: finish negation, apply saturation, derive the output sign
    always_comb begin
        res_data = s1_q.value;
        res_ovf  = 1'b0;
        if (s1_q.flags.ovf_pre) begin
            res_data = s1_q.flags.sign ? MIN_NEG : MAX_POS;
            res_ovf  = 1'b1;
        end else if (s1_q.flags.mode == MODE_TC2SM && s1_q.flags.is_min) begin
            // Most-negative TC input is exactly representable as a W-bit magnitude
            res_data = MIN_NEG;
        end else if (s1_q.flags.mode == MODE_SM2TC && s1_q.flags.sign && s1_q.flags.is_zero) begin
            res_data = '0;
        end else if (s1_q.flags.sign) begin
            res_data = s1_q.value + WORD_LENGTH'(1);
        end

        if (s1_q.flags.mode == MODE_TC2SM) begin
            res_sign = s1_q.flags.sign;
        end else begin
            res_sign = res_data[WORD_LENGTH-1];
        end
    end

    assign s2_d = {res_data, res_sign, res_ovf};

    sm_pipe_stage #(
        .WIDTH (S2_W)
    ) u_stage2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign {out_data, out_sign, out_overflow} = s2_q;

    assign fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || clear_count) begin
            done_count <= '0;
        end else if (fire && (done_count != '1)) begin
            done_count <= done_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sign_magnitude_pipe.sv
// Scoreboard bench for sign_magnitude_pipe: directed vectors, decoupled monitor.
module tb_sign_magnitude_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [15:0] in_data;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sign;
    logic        out_overflow;
    logic        clear_count;
    logic [3:0]  done_count;

    sign_magnitude_pipe #(
        .WORD_LENGTH (16),
        .COUNT_WIDTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_data      (in_data),
        .in_sign      (in_sign),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sign     (out_sign),
        .out_overflow (out_overflow),
        .clear_count  (clear_count),
        .done_count   (done_count)
    );

    typedef struct {
        logic [15:0] d;
        logic        s;
        logic        o;
        bit          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the word has been accepted.
    task automatic send(input logic m, input logic sg, input logic [15:0] d,
                        input logic [15:0] ed, input logic es, input logic eo, input bit lat);
        bit   acc;
        int   acyc;
        exp_t e;
        in_valid = 1'b1;
        in_mode  = m;
        in_sign  = sg;
        in_data  = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc  = in_ready;
            acyc = cyc;
            @(posedge clk);
            #1;
            if (acc) begin
                e.d = ed; e.s = es; e.o = eo; e.lat = lat; e.acc_cyc = acyc;
                sb.push_back(e);
                n_acc++;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        fail_now("send_accept");
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && sb.size() != 0; t++) @(posedge clk);
        if (sb.size() != 0) fail_now("drain");
        sync();
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.d));
                    check("out_sign", 32'(out_sign), 32'(mon_e.s));
                    check("out_overflow", 32'(out_overflow), 32'(mon_e.o));
                    if (mon_e.lat) check("latency", 32'(cyc - mon_e.acc_cyc), 32'd2);
                end
            end else if (sb.size() != 0) begin
                check("stall_data", 32'(out_data), 32'(sb[0].d));
                check("stall_sign", 32'(out_sign), 32'(sb[0].s));
                check("stall_ovf", 32'(out_overflow), 32'(sb[0].o));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_sign = 1'b0;
        out_ready = 1'b1; clear_count = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sign", 32'(out_sign), 32'd0);
        check("rst_out_ovf", 32'(out_overflow), 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        sync();

        // Mode 0 back-to-back with latency checks
        send(1'b0, 1'b0, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 16'hFFFB, 16'h0005, 1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b0, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b1, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1);
        drain();

        // Mode 1 incl. saturation and negative zero
        send(1'b1, 1'b1, 16'h0005, 16'hFFFB, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b1, 16'h8001, 16'h8000, 1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
        drain();

        // Backpressure: 5 cycles of out_ready=0 while streaming 4 words
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                send(1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0);
                send(1'b0, 1'b0, 16'hEDCC, 16'h1234, 1'b1, 1'b0, 1'b0);
                send(1'b1, 1'b1, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
                send(1'b1, 1'b0, 16'hFFFF, 16'h7FFF, 1'b0, 1'b1, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_accepted", 32'(n_acc), 32'd2);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Mode alternating every word
        send(1'b0, 1'b0, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b1, 16'h00FF, 16'hFF01, 1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b0, 16'hFF00, 16'h0100, 1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 16'h8001, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b1, 16'h7FFF, 16'h8001, 1'b1, 1'b0, 1'b1);
        drain();

        // Counter: clear, 3 words, then 17 more to saturate
        clear_count = 1'b1;
        sync();
        clear_count = 1'b0;
        @(negedge clk);
        check("cnt_cleared", 32'(done_count), 32'd0);
        sync();
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 16'(i + 1), 16'(i + 1), 1'b0, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        check("cnt_three", 32'(done_count), 32'd3);
        sync();
        for (int i = 0; i < 17; i++) send(1'b0, 1'b0, 16'(i + 16), 16'(i + 16), 1'b0, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        check("cnt_saturated", 32'(done_count), 32'hF);
        sync();

        // clear_count coinciding with an output transaction
        send(1'b0, 1'b0, 16'h0007, 16'h0007, 1'b0, 1'b0, 1'b0);
        begin : wait_out
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                if (out_valid) disable wait_out;
            end
            fail_now("clear_wait_out_valid");
        end
        clear_count = 1'b1;
        @(posedge clk);
        #1 clear_count = 1'b0;
        @(negedge clk);
        check("cnt_clear_priority", 32'(done_count), 32'd0);
        check("clear_txn_consumed", 32'(sb.size()), 32'd0);
        sync();

        // Reset with two words in flight
        out_ready = 1'b0;
        send(1'b0, 1'b0, 16'h0011, 16'h0011, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 16'h0002, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        sb.delete();
        sync();
        reset = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_done_count", 32'(done_count), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        sync();
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("flush_no_output", 32'(done_count), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
